// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: shared constants, FSM state and prefetch entry type for the fetch stage.
package i_fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] IF_NOP_INSTR = 32'h5400_0000;
    typedef enum logic [1:0] {IDLE, REQ, SQUASH} fetch_state_e;
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus_four;
    } fifo_entry_t;
endpackage

// File: rtl/i_fetch_if.sv
// i_fetch_if: instruction-memory request/ready handshake between fetch (master) and memory (slave).
interface i_fetch_if;
    import i_fetch_pkg::*;
    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ready;
    logic [WORD_W-1:0] data;
    modport master(output req, addr, input ready, data);
    modport slave(input req, addr, output ready, data);
endinterface

// File: rtl/i_fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {instr, pc_plus_four} entries with push/pop/flush.
module fetch_fifo
    import i_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fifo_entry_t                din,
    output fifo_entry_t                dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    fifo_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + PW'(push);
        rd_d  = flush ? '0 : rd_q + PW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/i_fetch.sv
// i_fetch: PC, imem fetch FSM, prefetch FIFO and IF/ID register feeding i_decode.
// Optional IF_PERF_CNT_EN adds fetch_count/bubble_count outputs.
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = IF_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_INSTR  = IF_NOP_INSTR,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] target,
    i_fetch_if.master         imem,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus_four,
    output logic              if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_count,
    output logic [WORD_W-1:0] bubble_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [WORD_W-1:0] instr_q, instr_d, ppf_q, ppf_d;
    logic              valid_q, valid_d;
    logic              push, pop, full, empty;
    logic [CW-1:0]     fifo_cnt;
    fifo_entry_t       head, entry;
    assign push  = state_q == REQ && imem.ready && !redirect;
    assign pop   = !stall && !redirect && !empty;
    assign entry = '{instr: imem.data, pc_plus_four: pc_q + 32'd4};
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect),
        .din(entry), .dout(head), .count(fifo_cnt), .full(full), .empty(empty)
    );
    // SQUASH keeps presenting the abandoned address while pc already holds the target.
    assign imem.req  = state_q != IDLE;
    assign imem.addr = state_q == SQUASH ? addr_q : pc_q;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = redirect ? (target & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
        case (state_q)
            IDLE:    state_d = full ? IDLE : REQ;
            REQ:     begin
                if (imem.ready)
                    state_d = (redirect || (fifo_cnt + CW'(push) - CW'(pop)) < DEPTH_C) ? REQ : IDLE;
                else if (redirect) begin
                    state_d = SQUASH;
                    addr_d  = pc_q;
                end
            end
            SQUASH:  state_d = imem.ready ? REQ : SQUASH;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        instr_d = stall ? instr_q : pop ? head.instr : NOP_INSTR;
        ppf_d   = pop ? head.pc_plus_four : ppf_q;
        valid_d = stall ? valid_q : pop;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            ppf_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ppf_q   <= ppf_d;
            valid_q <= valid_d;
        end
    end
    assign instruction  = instr_q;
    assign pc_plus_four = ppf_q;
    assign if_valid     = valid_q;
`ifdef IF_PERF_CNT_EN
    logic [WORD_W-1:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + 32'(push);
        bubble_cnt_d = bubble_cnt_q + 32'(!stall && !pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif
endmodule
